// File: rtl/tile_renderer_pipe.sv
// Two-stage playfield colouriser: pixel counters -> tile coordinates -> priority colour.
// A hit-flash state machine blinks the player tile for a fixed number of frames after a hit.
module tile_renderer_pipe #(
  parameter int unsigned HPIXELS      = 640,
  parameter int unsigned VPIXELS      = 480,
  parameter int unsigned BSIZE        = 40,
  parameter int unsigned BUFFER_ROW   = 11,
  parameter int unsigned NUM_BULLETS  = 3,
  parameter int unsigned DD_ROWS      = 5,
  parameter int unsigned DD_COLS      = 6,
  parameter int unsigned FLASH_FRAMES = 8,
  parameter int unsigned BLINK_FRAMES = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              pixel_en,
  input  logic [9:0]                        horiz_count,
  input  logic [9:0]                        vert_count,
  input  logic                              frame_start,
  input  logic [3:0]                        player_row,
  input  logic                              player_hit,
  input  logic [DD_ROWS*DD_COLS*12-1:0]     ddavers,
  input  logic [NUM_BULLETS*12-1:0]         bullet_color,
  input  logic [NUM_BULLETS*4-1:0]          bullet_x,
  input  logic [NUM_BULLETS*4-1:0]          bullet_y,
  output logic [3:0]                        red,
  output logic [3:0]                        green,
  output logic [3:0]                        blue,
  output logic                              rgb_valid,
  output logic                              flashing
);

  localparam int unsigned TW  = $clog2(1023 / BSIZE + 1);
  localparam int unsigned FCW = $clog2(FLASH_FRAMES + 1);

  typedef enum logic {IDLE = 1'b0, FLASH = 1'b1} state_t;

  state_t         state;
  logic [FCW-1:0] frame_cnt;
  logic           player_show;

  logic [TW-1:0]  tile_x1;
  logic [TW-1:0]  tile_y1;
  logic           vis1;
  logic           v1;

  logic           bullet_hit;
  logic [11:0]    bullet_rgb;
  logic [11:0]    dd_rgb;
  logic [11:0]    pix_rgb;

  // Hit-flash FSM; a new hit always restarts the flash, even on a frame boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      frame_cnt <= '0;
      flashing  <= 1'b0;
    end else if (player_hit) begin
      state     <= FLASH;
      frame_cnt <= '0;
      flashing  <= 1'b1;
    end else if (state == FLASH && frame_start) begin
      if (32'(frame_cnt) == FLASH_FRAMES - 1) begin
        state     <= IDLE;
        frame_cnt <= '0;
        flashing  <= 1'b0;
      end else begin
        frame_cnt <= frame_cnt + FCW'(1);
      end
    end
  end

  assign player_show = (state == IDLE) || (((32'(frame_cnt) / BLINK_FRAMES) % 2) == 0);

  // Stage 1: pixel counters to tile coordinates and visibility
  always_ff @(posedge clk) begin
    if (reset) begin
      tile_x1 <= '0;
      tile_y1 <= '0;
      vis1    <= 1'b0;
      v1      <= 1'b0;
    end else begin
      tile_x1 <= TW'(32'(horiz_count) / BSIZE);
      tile_y1 <= TW'(32'(vert_count) / BSIZE);
      vis1    <= (32'(horiz_count) < HPIXELS) && (32'(vert_count) < VPIXELS);
      v1      <= pixel_en;
    end
  end

  // Lowest-index active bullet on this tile wins
  always_comb begin
    bullet_hit = 1'b0;
    bullet_rgb = 12'h000;
    for (int unsigned i = 0; i < NUM_BULLETS; i++) begin
      if (!bullet_hit && bullet_color[i*12 +: 12] != 12'h000 &&
          32'(tile_x1) == 32'(bullet_x[i*4 +: 4]) &&
          32'(tile_y1) == 32'(bullet_y[i*4 +: 4])) begin
        bullet_hit = 1'b1;
        bullet_rgb = bullet_color[i*12 +: 12];
      end
    end
  end

  // DDaver (r,c) lives on tile (2c+4, 2r+1); tiles outside the grid match no entry
  always_comb begin
    dd_rgb = 12'h000;
    for (int unsigned r = 0; r < DD_ROWS; r++) begin
      for (int unsigned c = 0; c < DD_COLS; c++) begin
        if (32'(tile_y1) == 2 * r + 1 && 32'(tile_x1) == 2 * c + 4) begin
          dd_rgb = ddavers[(r*DD_COLS+c)*12 +: 12];
        end
      end
    end
  end

  always_comb begin
    pix_rgb = 12'h000;
    if (!vis1) begin
      pix_rgb = 12'h000;
    end else if (32'(tile_y1) == BUFFER_ROW) begin
      pix_rgb = 12'h777;
    end else if (tile_x1 == TW'(0)) begin
      pix_rgb = 12'h282;
    end else if (tile_x1 == TW'(1) && 32'(tile_y1) == 32'(player_row) && player_show) begin
      pix_rgb = 12'hFFF;
    end else if (bullet_hit) begin
      pix_rgb = bullet_rgb;
    end else begin
      pix_rgb = dd_rgb;
    end
  end

  // Stage 2: registered colour and valid
  always_ff @(posedge clk) begin
    if (reset) begin
      red       <= 4'h0;
      green     <= 4'h0;
      blue      <= 4'h0;
      rgb_valid <= 1'b0;
    end else begin
      red       <= pix_rgb[11:8];
      green     <= pix_rgb[7:4];
      blue      <= pix_rgb[3:0];
      rgb_valid <= v1;
    end
  end

endmodule

// File: doc/tile_renderer_pipe.md
Name: tile_renderer_pipe

Overview:
- Parametrised, pipelined successor to the combinational playfield colouriser.
- Maps the VGA pixel counters to tile coordinates and picks the pixel colour by fixed priority: buffer row, homeworld column, player Blockieee, bullets, DDaver grid, backdrop.
- Colour output is registered with a fixed 2-cycle latency.
- Adds a hit-flash state machine that blinks the player for a programmable number of frames after a hit.
- Sits between the VGA timing counters and the VGA pins.

Parameters:
- HPIXELS, 640, visible width in pixels
- VPIXELS, 480, visible height in pixels
- BSIZE, 40, tile edge in pixels
- BUFFER_ROW, 11, tile row painted grey
- NUM_BULLETS, 3, number of bullet slots
- DD_ROWS, 5, DDaver grid rows
- DD_COLS, 6, DDaver grid columns
- FLASH_FRAMES, 8, frames a hit flash lasts (>=1)
- BLINK_FRAMES, 2, frames per blink half-period (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- pixel_en  in  1  the counters are valid this cycle
- horiz_count  in  10  horizontal pixel counter
- vert_count  in  10  vertical pixel counter
- frame_start  in  1  one-cycle pulse at the start of each frame
- player_row  in  4  Blockieee tile row (column is fixed at 1)
- player_hit  in  1  one-cycle hit pulse
- ddavers  in  DD_ROWS*DD_COLS*12  flattened 12-bit RGB per DDaver; entry (r,c) is at bits [(r*DD_COLS+c)*12 +: 12]
- bullet_color  in  NUM_BULLETS*12  flattened RGB per bullet; 0 means slot inactive
- bullet_x  in  NUM_BULLETS*4  bullet tile column per slot
- bullet_y  in  NUM_BULLETS*4  bullet tile row per slot
- red, green, blue  out  4 each  registered colour
- rgb_valid  out  1  pixel_en delayed by 2 cycles
- flashing  out  1  high while the hit-flash state machine is in FLASH

Behaviour:
- Reset: red/green/blue=0, rgb_valid=0, flashing=0, FSM=IDLE, frame_cnt=0, all pipeline registers cleared.
- Stage 1 (registered):
  - tile_x = horiz_count/BSIZE; tile_y = vert_count/BSIZE.
  - vis = (horiz_count < HPIXELS) && (vert_count < VPIXELS). The full visible range is included; there is no minus-one off-by-one.
  - v1 = pixel_en.
- Stage 2 (registered): the priority selection below drives RGB, and rgb_valid = v1. Stage registers advance every cycle regardless of pixel_en.
- Priority, first match wins:
  1. !vis -> 0,0,0
  2. tile_y == BUFFER_ROW -> 7,7,7
  3. tile_x == 0 -> 2,8,2
  4. tile_x == 1, tile_y == player_row, and player_show -> 15,15,15
  5. Bullet i, lowest index first: tile_x == bullet_x[i], tile_y == bullet_y[i], bullet_color[i] != 0 -> bullet_color[i] as [11:8]/[7:4]/[3:0]
  6. tile_y odd, tile_x even, tile_x >= 4 -> DDaver (r,c) with r = tile_y/2, c = tile_x/2 - 2, provided r < DD_ROWS and c < DD_COLS; if either index is out of range -> 0,0,0. Out-of-range indices must never read the array.
  7. Otherwise -> 0,0,0
- Stage 2 uses the player/bullet/DDaver inputs as sampled in the stage-2 cycle. These inputs are frame-stable by contract.
- Hit-flash FSM, states IDLE and FLASH:
  - IDLE + player_hit -> FLASH with frame_cnt=0.
  - FLASH + player_hit -> stays in FLASH, frame_cnt=0 (restart).
  - FLASH + frame_start and no hit: if frame_cnt == FLASH_FRAMES-1 -> IDLE, frame_cnt=0; otherwise frame_cnt+1.
  - player_hit and frame_start in the same cycle: the hit wins (frame_cnt=0, state FLASH).
  - frame_cnt width is $clog2(FLASH_FRAMES+1).
  - player_show = 1 in IDLE. In FLASH, player_show = ((frame_cnt/BLINK_FRAMES) is even).
  - flashing = (state == FLASH), registered.
- A reset asserted mid-flash returns to IDLE immediately and forces the outputs to 0 on the next edge.

Test Plan:
- Reset, then drive pixel_en with (0,0) -> after 2 cycles rgb = 2,8,2 and rgb_valid = 1; during reset all outputs are 0.
- player_row=3, pixel (45,125) -> 15,15,15. Pixel (639,479) with tile (15,11) -> 7,7,7. Pixel (640,10) -> 0,0,0.
- bullet0 = (5,2, 0xF00) and bullet1 = (5,2, 0x0F0), pixel (205,85) -> 15,0,0; with bullet_color[0]=0 -> 0,15,0.
- ddavers(0,0)=0x00F, pixel (165,45) with tile (4,1) -> 0,0,15. Pixel (565,45) with tile (14,1), c=5 -> entry (0,5). Pixel (605,45) with tile (15,1), odd column -> 0,0,0.
- Hit pulse, then 8 frame_starts with BLINK_FRAMES=2: player colour shown/hidden pattern S,S,H,H,S,S,H,H per frame, then flashing drops after the 8th frame_start.
- Hit and frame_start in the same cycle during FLASH at frame_cnt=5 -> frame_cnt=0, still FLASH. Reset at frame_cnt=3 -> flashing=0 on the next cycle.
